// File: rtl/cu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cu_seq_pkg
// Purpose  : Shared types and constants for the cu_seq sequencing control
//            unit: 3-bit state encoding, default halt word and the
//            stage-strobe bundle.
// Revision : 1.0 - initial release
// ============================================================================
package cu_seq_pkg;

  // State encoding. Code 7 is deliberately left unused; the FSM treats it
  // as a corrupted register and drops into ST_ERROR.
  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALTED    = 3'd5,
    ST_ERROR     = 3'd6
  } state_e;

  // Default halt word (all zeros), sized for the widest expected bus.
  localparam logic [31:0] DEF_HALT_WORD = 32'h0000_0000;

  // One-cycle stage enables driven towards the datapath.
  typedef struct packed {
    logic ir_load;
    logic dec_en;
    logic exe_en;
    logic mem_req;
    logic wb_en;
  } strobes_t;

endpackage : cu_seq_pkg
`default_nettype wire

// File: rtl/cu_seq_perf.sv
`default_nettype none
// ============================================================================
// Module   : cu_seq_perf
// Purpose  : Saturating cycle and retire counters for cu_seq.
// Ports    : clk, rst          - clock, async active-high reset
//            running           - count this cycle towards cycle_count
//            retire_pulse      - one instruction completes on this edge
//            cycle_count       - cycles spent running (saturating)
//            retired_count     - instructions completed (saturating)
// Revision : 1.0 - initial release
// ============================================================================
module cu_seq_perf #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             running,
  input  logic             retire_pulse,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retired_count
);

  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] retired_q;

  // Both counters stick at all-ones instead of wrapping so that a long run
  // never reports a misleadingly small value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q   <= '0;
      retired_q <= '0;
    end else begin
      if (running && (cycle_q != {CNT_W{1'b1}})) begin
        cycle_q <= cycle_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (retire_pulse && (retired_q != {CNT_W{1'b1}})) begin
        retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign cycle_count   = cycle_q;
  assign retired_count = retired_q;

endmodule : cu_seq_perf
`default_nettype wire

// File: rtl/cu_seq.sv
`default_nettype none
// ============================================================================
// Module   : cu_seq
// Purpose  : Multi-cycle fetch/decode/execute/memory/writeback sequencer with
//            fetch and memory handshakes, memory timeout, global stall,
//            halt/resume, sticky error and performance counters.
// Ports    : clk, rst                 - clock, async active-high reset
//            instr_valid, instruction - fetch handshake / fetched word
//            mem_ready                - memory access completes this cycle
//            stall                    - freeze FETCH..WRITEBACK
//            resume                   - leave HALTED
//            program_running, error   - status (registered)
//            current_state            - state register
//            ir_load..wb_en           - stage strobes (combinational)
//            cycle_count, retired_count - performance counters
// Revision : 1.0 - initial release
// ============================================================================
module cu_seq
  import cu_seq_pkg::*;
#(
  parameter int                 INSTR_W     = 32,
  parameter logic [INSTR_W-1:0] HALT_WORD   = INSTR_W'(DEF_HALT_WORD),
  parameter int                 CNT_W       = 32,
  parameter int                 MEM_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               mem_ready,
  input  logic               stall,
  input  logic               resume,
  output logic               program_running,
  output logic [2:0]         current_state,
  output logic               ir_load,
  output logic               dec_en,
  output logic               exe_en,
  output logic               mem_req,
  output logic               wb_en,
  output logic               error,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [CNT_W-1:0]   retired_count
);

  localparam int WAIT_W = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              running_q, running_d;
  logic              error_q, error_d;
  strobes_t          w_strobes;
  logic              w_timeout_hit;
  logic              w_retire;

  // The current non-ready MEMORY cycle is the MEM_TIMEOUT-th one when the
  // counter already holds MEM_TIMEOUT-1 earlier waits.
  generate
    if (MEM_TIMEOUT != 0) begin : g_timeout
      assign w_timeout_hit = (wait_q == WAIT_W'(MEM_TIMEOUT - 1));
    end else begin : g_no_timeout
      assign w_timeout_hit = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      wait_q    <= '0;
      running_q <= 1'b1;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      running_q <= running_d;
      error_q   <= error_d;
    end
  end

  // Next state and strobes. A stalled cycle leaves the defaults in place,
  // which freezes state and wait counter and keeps every strobe low.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    w_strobes = '0;
    case (state_q)
      ST_FETCH: begin
        if (!stall && instr_valid) begin
          if (instruction == HALT_WORD) begin
            state_d = ST_HALTED;
          end else begin
            state_d           = ST_DECODE;
            w_strobes.ir_load = 1'b1;
          end
        end
      end
      ST_DECODE: begin
        if (!stall) begin
          w_strobes.dec_en = 1'b1;
          state_d          = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        if (!stall) begin
          w_strobes.exe_en = 1'b1;
          state_d          = ST_MEMORY;
          wait_d           = '0;
        end
      end
      ST_MEMORY: begin
        if (!stall) begin
          w_strobes.mem_req = 1'b1;
          // A completion on the limit cycle still wins over the timeout.
          if (mem_ready) begin
            state_d = ST_WRITEBACK;
          end else if (w_timeout_hit) begin
            state_d = ST_ERROR;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
      end
      ST_WRITEBACK: begin
        if (!stall) begin
          w_strobes.wb_en = 1'b1;
          state_d         = ST_FETCH;
        end
      end
      ST_HALTED: begin
        if (resume) begin
          state_d = ST_FETCH;
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_ERROR;
      end
    endcase
  end

  // Status flags follow the state being entered so they change on the same
  // edge as current_state.
  always_comb begin
    running_d = !((state_d == ST_HALTED) || (state_d == ST_ERROR));
    error_d   = error_q || (state_d == ST_ERROR);
  end

  assign w_retire = (state_q == ST_WRITEBACK) && !stall;

  cu_seq_perf #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk           (clk),
    .rst           (rst),
    .running       (running_q),
    .retire_pulse  (w_retire),
    .cycle_count   (cycle_count),
    .retired_count (retired_count)
  );

  assign current_state   = state_q;
  assign program_running = running_q;
  assign error           = error_q;
  assign ir_load         = w_strobes.ir_load;
  assign dec_en          = w_strobes.dec_en;
  assign exe_en          = w_strobes.exe_en;
  assign mem_req         = w_strobes.mem_req;
  assign wb_en           = w_strobes.wb_en;

endmodule : cu_seq
`default_nettype wire
